// File: rtl/uart_transmitter.sv
// 8N1 UART serializer: one start bit, eight data bits LSB-first, one stop bit.
// Bit timing comes from a fixed clocks-per-bit divider; all outputs are registered.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 68
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_reg,   state_next;
  logic [CNT_W-1:0] clk_cnt_reg, clk_cnt_next;
  logic [2:0]       bit_idx_reg, bit_idx_next;
  logic [7:0]       shift_reg,   shift_next;
  logic             tx_reg,      tx_next;
  logic             busy_reg,    busy_next;
  logic             done_reg,    done_next;
  logic             bit_end;

  assign bit_end = (clk_cnt_reg == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      clk_cnt_reg <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      tx_reg      <= 1'b1;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      clk_cnt_reg <= clk_cnt_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      tx_reg      <= tx_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    clk_cnt_next = clk_cnt_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    tx_next      = tx_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        tx_next   = 1'b1;
        busy_next = 1'b0;
        if (tx_start) begin
          shift_next   = tx_data;
          tx_next      = 1'b0;
          busy_next    = 1'b1;
          clk_cnt_next = '0;
          state_next   = START;
        end
      end

      START: begin
        if (bit_end) begin
          clk_cnt_next = '0;
          bit_idx_next = '0;
          tx_next      = shift_reg[0];
          state_next   = DATA;
        end else begin
          clk_cnt_next = clk_cnt_reg + 1'b1;
        end
      end

      DATA: begin
        if (bit_end) begin
          clk_cnt_next = '0;
          if (bit_idx_reg == 3'd7) begin
            tx_next    = 1'b1;
            state_next = STOP;
          end else begin
            // The shifter always presents the bit currently on the line at [0].
            bit_idx_next = bit_idx_reg + 3'd1;
            shift_next   = shift_reg >> 1;
            tx_next      = shift_reg[1];
          end
        end else begin
          clk_cnt_next = clk_cnt_reg + 1'b1;
        end
      end

      STOP: begin
        if (bit_end) begin
          clk_cnt_next = '0;
          busy_next    = 1'b0;
          done_next    = 1'b1;
          state_next   = IDLE;
        end else begin
          clk_cnt_next = clk_cnt_reg + 1'b1;
        end
      end

      default: begin
        tx_next    = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  assign tx      = tx_reg;
  assign tx_busy = busy_reg;
  assign tx_done = done_reg;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: a frame-level acceptance model feeds a scoreboard
// queue, and a line receiver pops and checks each frame it decodes from tx.
module tb_uart_transmitter;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx, tx_busy, tx_done;

  uart_transmitter #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a request is taken whenever no frame is outstanding, and a
  // frame occupies the line for ten bit times after the edge that took it.
  typedef struct {
    logic [7:0]  data;
    int unsigned cyc;
  } exp_t;

  exp_t        acc_q[$];
  int unsigned cyc       = 0;
  int          left      = 0;
  int          acc_count = 0;
  int          exp_done  = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      left = 0;
      acc_q.delete();
    end else begin
      cyc++;
      if (left == 0) begin
        if (tx_start) begin
          acc_q.push_back('{data: tx_data, cyc: cyc});
          left = FRAME;
          acc_count++;
          $display("accept  data=0x%02h cycle=%0d", tx_data, cyc);
        end
      end else begin
        left--;
        if (left == 0) exp_done++;
      end
    end
  end

  // Monitor: behavioural receiver sampling mid-bit, checks timing and content.
  logic        rx_active = 1'b0;
  logic        prev_tx   = 1'b1;
  int          rx_cnt    = 0;
  logic [9:0]  samples   = '0;
  logic        busy_ok   = 1'b1;
  exp_t        cur;
  int          done_seen = 0;

  always @(negedge clk) begin
    if (rst) begin
      rx_active = 1'b0;
      prev_tx   = 1'b1;
    end else begin
      if (!rx_active) begin
        if (prev_tx && !tx) begin
          rx_active = 1'b1;
          rx_cnt    = 0;
          samples   = '0;
          busy_ok   = tx_busy;
          if (acc_q.size() == 0) begin
            check("unexpected_frame", 32'd1, 32'd0);
            cur = '{data: 8'h00, cyc: cyc};
          end else begin
            cur = acc_q.pop_front();
            check("start_latency", cyc, cur.cyc);
          end
        end
      end else begin
        rx_cnt++;
        if (rx_cnt < FRAME) busy_ok = busy_ok & tx_busy;
        if (rx_cnt % CPB == CPB / 2) samples[rx_cnt / CPB] = tx;
        if (rx_cnt == FRAME) begin
          $display("frame   got=0x%02h exp=0x%02h start=%0b stop=%0b",
                   samples[8:1], cur.data, samples[0], samples[9]);
          check("start_bit", 32'(samples[0]), 32'd0);
          check("data_bits", 32'(samples[8:1]), 32'(cur.data));
          check("stop_bit", 32'(samples[9]), 32'd1);
          check("busy_during_frame", 32'(busy_ok), 32'd1);
          check("busy_fall_at_40", 32'(tx_busy), 32'd0);
          check("done_at_frame_end", 32'(tx_done), 32'd1);
          rx_active = 1'b0;
        end
      end
      prev_tx = tx;
      if (tx_done) done_seen++;
    end
  end

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    tx_start = 1'b1;
    tx_data  = d;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 200 && (tx_busy || left != 0 || rx_active); i++) @(negedge clk);
    check("idle_timeout", 32'(i < 200), 32'd1);
  endtask

  task automatic wait_acc(input int target);
    int i;
    for (i = 0; i < 200 && acc_count < target; i++) @(negedge clk);
    check("accept_timeout", 32'(acc_count >= target), 32'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_busy", 32'(tx_busy), 32'd0);
    check("reset_done", 32'(tx_done), 32'd0);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_line", {29'd0, tx, tx_busy, tx_done}, 32'b100);
    end

    send(8'h55);
    wait_idle();

    // Spurious request with different data during data bit 3 must be ignored.
    send(8'hA3);
    repeat (16) @(negedge clk);
    tx_start = 1'b1;
    tx_data  = 8'hFF;
    @(negedge clk);
    tx_start = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk);
    check("no_queued_frame", 32'(acc_count), 32'd2);
    check("done_count_a3", 32'(done_seen), 32'd2);

    // Held request retriggers; data changes after acceptance stay invisible.
    begin
      int base;
      base = acc_count;
      @(negedge clk);
      tx_start = 1'b1;
      tx_data  = 8'h0F;
      wait_acc(base + 1);
      repeat (10) @(negedge clk);
      tx_data = 8'hF0;
      wait_acc(base + 2);
      @(negedge clk);
      tx_start = 1'b0;
      wait_idle();
    end

    // Asynchronous reset between edges during data bit 4.
    send(8'h3C);
    repeat (21) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_tx", 32'(tx), 32'd1);
    check("async_rst_busy", 32'(tx_busy), 32'd0);
    check("async_rst_done", 32'(tx_done), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("no_done_after_abort", 32'(done_seen), 32'(exp_done));

    send(8'h81);
    wait_idle();

    // Random request pulses, including ones that land mid-frame.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      tx_start = ($urandom_range(0, 7) == 0);
      tx_data  = 8'($urandom);
    end
    @(negedge clk);
    tx_start = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk);

    check("scoreboard_empty", 32'(acc_q.size()), 32'd0);
    check("done_pulses", 32'(done_seen), 32'(exp_done));
    check("final_idle", {29'd0, tx, tx_busy, tx_done}, 32'b100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
